// File: rtl/if_stage_pipe.sv
// Instruction-fetch stage: PC register, combinational imem address, IF/ID pipeline
// register with freeze/flush/redirect handling, plus fetch and redirect counters.
module if_stage_pipe #(
    parameter int                  ADDR_W    = 32,
    parameter int                  INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = '0,
    parameter int                  RCNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    input  logic               flush,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic               if_id_valid,
    output logic [31:0]        fetch_count,
    output logic [RCNT_W-1:0]  redirect_count
);

    function automatic logic [RCNT_W-1:0] sat_inc(input logic [RCNT_W-1:0] v);
        if (&v) return v;
        return v + RCNT_W'(1);
    endfunction

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              squash;
    logic              capture;

    assign imem_addr = pc;
    assign pc_plus4  = pc + ADDR_W'(4);
    assign squash    = flush | branch_taken;
    assign capture   = !squash && !freeze;

    // Stage IF: program counter; a taken branch overrides a hazard freeze
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (branch_taken) begin
            pc <= {branch_addr[ADDR_W-1:2], 2'b00};
        end else if (!freeze) begin
            pc <= pc_plus4;
        end
    end

    // Stage IF/ID boundary: squash beats freeze, freeze holds, otherwise capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (squash) begin
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
        end else if (capture) begin
            if_id_pc    <= pc_plus4;
            if_id_instr <= imem_data;
            if_id_valid <= 1'b1;
        end
    end

    // Performance counters: fetches wrap, redirects saturate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (capture)      fetch_count    <= fetch_count + 32'd1;
            if (branch_taken) redirect_count <= sat_inc(redirect_count);
        end
    end

endmodule

// File: tb/tb_if_stage_pipe.sv
// Scoreboard bench for if_stage_pipe: a fetch-stage reference model predicts each
// edge's outcome into a queue; a monitor pops and compares after every rising edge.
module tb_if_stage_pipe;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        flush;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic [15:0] redirect_count;

    if_stage_pipe dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .flush(flush), .imem_addr(imem_addr),
        .imem_data(imem_data), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count),
        .redirect_count(redirect_count)
    );

    logic [31:0] mem [256];
    assign imem_data = mem[imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic        valid;
        logic [31:0] fc;
        logic [15:0] rc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_ipc, m_fc;
    logic        m_valid;
    int          m_rc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem[(a / 4) % 256];
    endfunction

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_fc = 0; m_rc = 0;
    endtask

    // drive one edge's inputs and predict the state after that edge
    task automatic apply(input logic bt, input logic [31:0] ba, input logic fr, input logic fl);
        exp_t e;
        logic [31:0] old_pc;
        branch_taken = bt; branch_addr = ba; freeze = fr; flush = fl;
        old_pc = m_pc;
        if (bt)       m_pc = ba - (ba % 4);
        else if (!fr) m_pc = old_pc + 4;
        if (fl || bt) begin
            m_instr = 0; m_ipc = 0; m_valid = 0;
        end else if (!fr) begin
            m_instr = mem_word(old_pc); m_ipc = old_pc + 4; m_valid = 1; m_fc = m_fc + 1;
        end
        if (bt && m_rc < 65535) m_rc = m_rc + 1;
        e.pc = m_pc; e.instr = m_instr; e.ipc = m_ipc; e.valid = m_valid;
        e.fc = m_fc; e.rc = 16'(m_rc);
        q.push_back(e);
    endtask

    task automatic cyc(input logic bt, input logic [31:0] ba, input logic fr, input logic fl);
        @(negedge clk);
        apply(bt, ba, fr, fl);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_imem_addr"}, imem_addr, 32'h0);
        chk({tag, "_if_id_pc"}, if_id_pc, 32'h0);
        chk({tag, "_if_id_instr"}, if_id_instr, 32'h0);
        chk({tag, "_if_id_valid"}, {31'b0, if_id_valid}, 32'h0);
        chk({tag, "_fetch_count"}, fetch_count, 32'h0);
        chk({tag, "_redirect_count"}, {16'b0, redirect_count}, 32'h0);
    endtask

    // monitor: compare every predicted edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr", imem_addr, e.pc);
                chk("if_id_instr", if_id_instr, e.instr);
                chk("if_id_pc", if_id_pc, e.ipc);
                chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, e.valid});
                chk("fetch_count", fetch_count, e.fc);
                chk("redirect_count", {16'b0, redirect_count}, {16'b0, e.rc});
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'hE3A00014;
        mem[1] = 32'hE3A01A01;
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; flush = 1'b0;
        model_reset();
        #2;
        chk_reset_outputs("reset_initial");
        repeat (2) @(negedge clk);

        // release, then two sequential fetches from address 0
        rst = 1'b1;
        apply(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // freeze three cycles at pc=12, then release
        repeat (3) cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        // redirect to 148, then branch to 112 while frozen
        cyc(1, 148, 0, 0);
        cyc(1, 112, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // flush alone at pc=40, flush while frozen, misaligned target
        cyc(1, 40, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        cyc(1, 32'h73, 0, 0);
        cyc(0, 0, 0, 0);
        // PC wrap from 0xFFFFFFFC
        cyc(1, 32'hFFFF_FFFF, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 8) == 0, $urandom, ($urandom % 4) == 0, ($urandom % 8) == 0);
        end

        // long redirect run to hit counter saturation
        for (int i = 0; i < 70000; i++) begin
            cyc(1, $urandom, ($urandom % 2) == 0, 0);
        end
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // asynchronous reset mid-cycle while frozen
        cyc(0, 0, 1, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        chk_reset_outputs("reset_async");
        repeat (2) @(posedge clk);
        #2;
        chk_reset_outputs("reset_held");
        @(negedge clk);
        rst = 1'b1;
        apply(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/if_stage_pipe.md
Name: if_stage_pipe

Overview:
Instruction-fetch stage of the 5-stage ARM-subset pipeline. It holds the PC and drives the byte address to the combinational-read, big-endian-byte instruction memory. It captures the returned word plus PC+4 into the IF/ID pipeline register. It also handles hazard freeze, branch redirect and flush, and keeps two performance counters.

Parameters:
ADDR_W, 32, PC / memory address width (bytes)
INSTR_W, 32, instruction width
RESET_PC, 0, PC value on reset
NOP_INSTR, 32'h0000_0000, word inserted into IF/ID on flush/reset
RCNT_W, 16, width of redirect counter

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
freeze  in  1  hazard-unit stall; hold PC and IF/ID
branch_taken  in  1  from EXE; redirect PC this cycle
branch_addr  in  ADDR_W  branch target (byte address)
flush  in  1  squash instruction entering IF/ID
imem_addr  out  ADDR_W  address to instruction memory (= PC)
imem_data  in  INSTR_W  instruction word returned combinationally
if_id_pc  out  ADDR_W  PC+4 of captured instruction
if_id_instr  out  INSTR_W  captured instruction
if_id_valid  out  1  IF/ID holds a real instruction
fetch_count  out  32  instructions accepted into IF/ID
redirect_count  out  RCNT_W  branch redirects taken, saturating

Behaviour:
- Reset (rst=0, async, immediate, also mid-run): pc=RESET_PC; if_id_pc=0; if_id_instr=NOP_INSTR; if_id_valid=0; fetch_count=0; redirect_count=0. imem_addr follows pc, so it reads RESET_PC during reset.
- imem_addr = pc, purely combinational. Instruction memory has zero latency: imem_data is valid in the same cycle.
- PC update, per rising edge, in priority order:
  1. branch_taken: pc <= {branch_addr[ADDR_W-1:2], 2'b00}. This wins over freeze.
  2. !freeze: pc <= pc + 4, wrapping modulo 2^ADDR_W (0xFFFF_FFFC -> 0).
  3. Otherwise pc holds.
- IF/ID update, per rising edge, in priority order:
  1. flush or branch_taken: if_id_instr <= NOP_INSTR, if_id_valid <= 0, if_id_pc <= 0. Flush wins over freeze.
  2. !freeze: if_id_instr <= imem_data, if_id_pc <= pc + 4 (same wrap), if_id_valid <= 1.
  3. freeze: all three hold.
- Latency: instruction at address A appears on if_id_instr one edge after pc==A with freeze=0. Steady state is 1 instruction per cycle.
- fetch_count: +1 on each edge where IF/ID takes case 2 (valid capture). Wraps at 2^32.
- redirect_count: +1 on each edge with branch_taken=1. Saturates at all-ones, no wrap.
- Simultaneous branch_taken + freeze: PC redirects, IF/ID squashed, no fetch counted.
- Simultaneous flush + freeze without branch: PC holds, IF/ID squashed.
- branch_addr[1:0] is ignored (forced word alignment). No misalignment error is raised.
- No internal state machine beyond the PC and IF/ID registers.

Test Plan:
- Reset release, memory word0=32'hE3A00014, word1=32'hE3A01A01, freeze=0 -> imem_addr=0 during reset. After edge 1: if_id_instr=E3A00014, if_id_pc=4, if_id_valid=1, imem_addr=4. After edge 2: if_id_instr=E3A01A01, if_id_pc=8, fetch_count=2.
- freeze=1 for 3 cycles at pc=12 -> imem_addr stays 12; IF/ID holds the word from addr 8 with if_id_pc=12; fetch_count unchanged. On release, next edge captures addr 12 with if_id_pc=16.
- branch_taken=1 with branch_addr=112 while pc=148, freeze=1 -> next edge: pc=112, if_id_valid=0, if_id_instr=NOP_INSTR, redirect_count+1. Following edge captures word at 112 with if_id_pc=116.
- flush=1 alone at pc=40 -> IF/ID squashed (valid=0, pc 0), pc=44, fetch_count unchanged. branch_addr=0x73 with branch_taken -> pc=0x70.
- Force pc to 0xFFFFFFFC via branch, run 1 cycle -> if_id_pc=0, pc=0. Issue 70000 redirects -> redirect_count=0xFFFF held.
- Assert rst=0 asynchronously mid-cycle during freeze -> all outputs at reset values before the next clock edge. Deassert -> fetch restarts at RESET_PC.
